// File: rtl/hexuart_receiver_pkg.sv
// hexuart_receiver_pkg: ASCII constants, FSM encodings and bit-timing helpers shared by the hexuart chain.
package hexuart_receiver_pkg;
    localparam logic [7:0] ASCII_LF = 8'h0a;
    localparam logic [7:0] ASCII_CR = 8'h0d;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_UA = 8'h41;
    localparam logic [7:0] ASCII_LA = 8'h61;

    typedef enum logic [1:0] {P_PREFIX, P_HEX, P_LF} line_state_t;
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} byte_state_t;

    function automatic int sample_clks(input int clkfreq, input int baudrate);
        return clkfreq / baudrate;
    endfunction

    // {valid, nibble}; valid is low for anything outside 0-9, A-F, a-f
    function automatic logic [4:0] hex_nibble(input logic [7:0] c);
        return (c >= ASCII_0  && c <= 8'h39) ? {1'b1, 4'(c - ASCII_0)} :
               (c >= ASCII_UA && c <= 8'h46) ? {1'b1, 4'(c - ASCII_UA + 8'd10)} :
               (c >= ASCII_LA && c <= 8'h66) ? {1'b1, 4'(c - ASCII_LA + 8'd10)} : 5'd0;
    endfunction
endpackage

// File: rtl/hexuart_receiver_if.sv
// hexuart_receiver_if: serial input and parsed-record outputs of the hexuart receiver.
interface hexuart_receiver_if;
    logic        rx;
    logic [7:0]  prefix;
    logic [31:0] value;
    logic        newval;
    logic        frame_err;
    logic        parse_err;

    modport slave  (input rx, output prefix, value, newval, frame_err, parse_err);
    modport master (output rx, input prefix, value, newval, frame_err, parse_err);
endinterface

// File: rtl/hexuart_rx_byte.sv
// hexuart_rx_byte: rx synchroniser and 8N1 byte deserialiser with glitch rejection and break recovery.
module hexuart_rx_byte import hexuart_receiver_pkg::*; #(
    parameter int SAMPLECLK = 434
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       frame_err
);
    localparam logic [15:0] W_FULL = 16'(SAMPLECLK - 1);
    localparam logic [15:0] W_HALF = 16'(SAMPLECLK / 2 - 1);

    byte_state_t r_state, w_next;
    logic        r_rx_meta, r_rx_s;
    logic [15:0] r_timer;
    logic [2:0]  r_bit;
    logic [7:0]  r_shift;
    logic        w_tick;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) {r_rx_meta, r_rx_s} <= 2'b11;
        else {r_rx_meta, r_rx_s} <= {rx, r_rx_meta};

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) r_state <= S_IDLE;
        else r_state <= w_next;

    assign w_tick = r_timer == 16'd0 && (r_state == S_START || r_state == S_DATA || r_state == S_STOP);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = r_rx_s ? S_IDLE : S_START;
            S_START: w_next = !w_tick ? S_START : r_rx_s ? S_IDLE : S_DATA;
            S_DATA:  w_next = (w_tick && r_bit == 3'd7) ? S_STOP : S_DATA;
            S_STOP:  w_next = !w_tick ? S_STOP : r_rx_s ? S_IDLE : S_BREAK;
            S_BREAK: w_next = r_rx_s ? S_IDLE : S_BREAK;
            default: w_next = S_IDLE;
        endcase
    end

    // Idle preloads the half-bit delay so the start bit is sampled mid-bit
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            r_timer <= 16'd0;
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
        end else begin
            r_timer <= (r_state == S_IDLE) ? W_HALF :
                       (w_tick || r_state == S_BREAK) ? W_FULL : r_timer - 16'd1;
            r_bit   <= (r_state != S_DATA) ? 3'd0 : w_tick ? r_bit + 3'd1 : r_bit;
            if (r_state == S_DATA && w_tick) r_shift <= {r_rx_s, r_shift[7:1]};
        end

    always_comb begin
        byte_out   = r_shift;
        byte_valid = r_state == S_STOP && w_tick && r_rx_s;
        frame_err  = r_state == S_STOP && w_tick && !r_rx_s;
    end
endmodule

// File: rtl/hexuart_receiver.sv
// hexuart_receiver: parses "<prefix><8 hex>LF" lines from the serial rx line into {prefix,value} records.
module hexuart_receiver import hexuart_receiver_pkg::*; #(
    parameter int CLKFREQ  = 50000000,
    parameter int BAUDRATE = 115200
) (
    input logic              clk,
    input logic              reset_n,
    hexuart_receiver_if.slave bus
);
    localparam int SAMPLECLK = sample_clks(CLKFREQ, BAUDRATE);

    logic [7:0]  w_byte;
    logic        w_byte_valid, w_frame_err;
    line_state_t r_lstate, w_lnext;
    logic [4:0]  w_hex;
    logic        w_printable, w_take_prefix, w_take_digit, w_commit, w_perr;
    logic [31:0] r_acc, r_value;
    logic [7:0]  r_pfx, r_prefix;
    logic [2:0]  r_cnt;
    logic        r_newval, r_parse_err, r_frame_err;

    hexuart_rx_byte #(.SAMPLECLK(SAMPLECLK)) u_byte (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx         (bus.rx),
        .byte_out   (w_byte),
        .byte_valid (w_byte_valid),
        .frame_err  (w_frame_err)
    );

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) r_lstate <= P_PREFIX;
        else r_lstate <= w_lnext;

    // A framing error abandons the partial line silently
    always_comb begin
        w_lnext = w_frame_err ? P_PREFIX :
                  !w_byte_valid ? r_lstate :
                  (r_lstate == P_PREFIX) ? (w_printable ? P_HEX : P_PREFIX) :
                  (r_lstate == P_HEX && w_hex[4]) ? (r_cnt == 3'd7 ? P_LF : P_HEX) : P_PREFIX;
    end

    always_comb begin
        w_hex         = hex_nibble(w_byte);
        w_printable   = w_byte >= 8'h21 && w_byte <= 8'h7e && w_byte != ASCII_LF && w_byte != ASCII_CR;
        w_take_prefix = w_byte_valid && r_lstate == P_PREFIX && w_printable;
        w_take_digit  = w_byte_valid && r_lstate == P_HEX && w_hex[4];
        w_commit      = w_byte_valid && r_lstate == P_LF && w_byte == ASCII_LF;
        w_perr        = w_byte_valid && ((r_lstate == P_HEX && !w_hex[4]) ||
                                         (r_lstate == P_LF && w_byte != ASCII_LF));
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            r_acc       <= 32'd0;
            r_pfx       <= 8'd0;
            r_cnt       <= 3'd0;
            r_prefix    <= 8'd0;
            r_value     <= 32'd0;
            r_newval    <= 1'b0;
            r_parse_err <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_newval    <= w_commit;
            r_parse_err <= w_perr;
            r_frame_err <= w_frame_err;
            if (w_take_prefix) begin
                r_pfx <= w_byte;
                r_cnt <= 3'd0;
            end
            if (w_take_digit) begin
                r_acc <= {r_acc[27:0], w_hex[3:0]};
                r_cnt <= r_cnt + 3'd1;
            end
            if (w_commit) begin
                r_prefix <= r_pfx;
                r_value  <= r_acc;
            end
        end

    assign bus.prefix    = r_prefix;
    assign bus.value     = r_value;
    assign bus.newval    = r_newval;
    assign bus.frame_err = r_frame_err;
    assign bus.parse_err = r_parse_err;
endmodule

// File: tb/tb_hexuart_receiver.sv
// tb_hexuart_receiver: directed checks of the hexuart line receiver at 10 clocks per bit.
module tb_hexuart_receiver;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp = 0, n_err = 0;
    int   n_nv = 0, n_fe = 0, n_pe = 0, n_overlap = 0;
    int   cyc = 0, start_cyc = 0, nv_cyc = 0;

    always #5 clk = ~clk;

    hexuart_receiver_if bus();

    hexuart_receiver #(.CLKFREQ(1000), .BAUDRATE(100)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.newval) begin
            n_nv++;
            nv_cyc = cyc;
        end
        if (bus.frame_err) n_fe++;
        if (bus.parse_err) n_pe++;
        if (bus.newval && (bus.frame_err || bus.parse_err)) n_overlap++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        bus.rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        bus.rx = 1'b0;
        start_cyc = cyc;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            repeat (10) @(negedge clk);
        end
        bus.rx = stop;
        repeat (9) @(negedge clk);
        bus.rx = 1'b1;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
    endtask

    // Behavioural stand-in for the hexuart transmit chain (uppercase hex)
    task automatic tx_record(input logic [7:0] p, input logic [31:0] v);
        logic [3:0] n;
        send_byte(p, 1'b1);
        for (int i = 7; i >= 0; i--) begin
            n = v[i*4 +: 4];
            send_byte(n < 4'd10 ? 8'h30 + 8'(n) : 8'h37 + 8'(n), 1'b1);
        end
        send_byte(8'h0a, 1'b1);
    endtask

    initial begin
        bus.rx = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_prefix", 32'(bus.prefix), 32'h0);
        chk("rst_value", bus.value, 32'h0);
        chk("rst_newval", 32'(bus.newval), 32'h0);
        chk("rst_frame_err", 32'(bus.frame_err), 32'h0);
        chk("rst_parse_err", 32'(bus.parse_err), 32'h0);
        reset_n = 1'b1;
        idle(20);

        tx_record(8'h64, 32'h0fff0001);
        idle(30);
        chk("s1_newvals", n_nv, 1);
        chk("s1_prefix", 32'(bus.prefix), 32'h64);
        chk("s1_value", bus.value, 32'h0fff0001);
        chk("s1_latency", 32'((nv_cyc - start_cyc) inside {[90:102]}), 1);

        send_str("i00abcdef\n\r");
        idle(30);
        chk("s2_newvals", n_nv, 2);
        chk("s2_prefix", 32'(bus.prefix), 32'h69);
        chk("s2_value", bus.value, 32'h00abcdef);
        chk("s2_parse_errs", n_pe, 0);
        chk("s2_frame_errs", n_fe, 0);

        // After 'G' the rest re-parses as prefix '4' + 4 digits, so LF errors again
        send_str("d12G45678\n");
        idle(30);
        chk("s3a_newvals", n_nv, 2);
        chk("s3a_parse_errs", n_pe, 2);
        chk("s3a_value_held", bus.value, 32'h00abcdef);
        send_str("d00000480\n");
        idle(30);
        chk("s3b_newvals", n_nv, 3);
        chk("s3b_prefix", 32'(bus.prefix), 32'h64);
        chk("s3b_value", bus.value, 32'h00000480);

        send_str("x12");
        send_byte(8'h33, 1'b0);
        idle(40);
        chk("s4_frame_errs", n_fe, 1);
        chk("s4_newvals_broken", n_nv, 3);
        send_str("x89ABCDEF\n");
        idle(30);
        chk("s4_newvals", n_nv, 4);
        chk("s4_prefix", 32'(bus.prefix), 32'h78);
        chk("s4_value", bus.value, 32'h89abcdef);
        chk("s4_parse_errs", n_pe, 2);

        @(negedge clk);
        bus.rx = 1'b0;
        repeat (3) @(negedge clk);
        idle(40);
        chk("s5_newvals", n_nv, 4);
        chk("s5_frame_errs", n_fe, 1);
        chk("s5_parse_errs", n_pe, 2);
        chk("s5_value", bus.value, 32'h89abcdef);

        send_str("r1234");
        @(negedge clk);
        bus.rx = 1'b0;
        repeat (25) @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("s6_rst_prefix", 32'(bus.prefix), 32'h0);
        chk("s6_rst_value", bus.value, 32'h0);
        bus.rx = 1'b1;
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        idle(30);
        chk("s6_no_pulse_after_release", n_nv, 4);
        send_str("r00000005\n");
        idle(30);
        chk("s6_newvals", n_nv, 5);
        chk("s6_prefix", 32'(bus.prefix), 32'h72);
        chk("s6_value", bus.value, 32'h00000005);
        chk("s6_parse_errs", n_pe, 2);
        chk("s6_frame_errs", n_fe, 1);
        chk("pulse_overlap", n_overlap, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
